// File: rtl/branch_verify_queue_if.sv
// Signal bundle between IF/WB (master side) and the branch verify queue (slave side).
// Optional stat_ctrl/stat_mispredict appear only when BRVQ_STATS_EN is defined.
interface branch_verify_queue_if;
   // push_valid is the only request qualifier; full is the ready indication and a push
   // made while full (with no retire freeing a slot that cycle) is dropped, not held.
   logic        push_valid;
   logic [15:0] push_pc;
   logic        push_hit;
   logic [15:0] push_target;
   logic        full;
   logic        empty;
   logic        wb_valid;
   logic [15:0] wb_pc;
   logic        wb_is_ctrl;
   logic        wb_taken;
   logic [15:0] wb_target;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        btb_update;
   logic [15:0] btb_update_pc;
   logic [15:0] btb_update_target;
   logic        sync_err;
   logic        state_dbg;
`ifdef BRVQ_STATS_EN
   logic [15:0] stat_ctrl;
   logic [15:0] stat_mispredict;
`endif

   modport master (
      output push_valid, push_pc, push_hit, push_target,
      output wb_valid, wb_pc, wb_is_ctrl, wb_taken, wb_target,
      input  full, empty, redirect, redirect_pc,
      input  btb_update, btb_update_pc, btb_update_target, sync_err, state_dbg
`ifdef BRVQ_STATS_EN
      , input stat_ctrl, stat_mispredict
`endif
   );

   modport slave (
      input  push_valid, push_pc, push_hit, push_target,
      input  wb_valid, wb_pc, wb_is_ctrl, wb_taken, wb_target,
      output full, empty, redirect, redirect_pc,
      output btb_update, btb_update_pc, btb_update_target, sync_err, state_dbg
`ifdef BRVQ_STATS_EN
      , output stat_ctrl, stat_mispredict
`endif
   );
endinterface

// File: rtl/branch_verify_queue.sv
// In-order queue of IF next-PC predictions, verified at WB retire; issues redirect/BTB training.
// Optional retire statistics are enabled with BRVQ_STATS_EN.
module branch_verify_queue #(
   parameter  int DEPTH = 8,
   localparam int PTRW  = $clog2(DEPTH)
) (
   input logic                 clk,
   input logic                 rst,
   branch_verify_queue_if.slave bus
);
   typedef enum logic {TRACK = 1'b0, FLUSH = 1'b1} state_t;

   state_t            state, state_nxt;
   logic [15:0]       pc_mem  [DEPTH];
   logic [15:0]       tgt_mem [DEPTH];
   logic [DEPTH-1:0]  hit_mem;
   logic [PTRW-1:0]   head, tail;
   logic [PTRW:0]     count;

   logic [15:0]       head_pc, head_tgt, pred_next, act_next;
   logic              head_hit, retire, pc_bad, mispredict, flush, train, push_ok;

   assign bus.full      = (count == (PTRW+1)'(DEPTH));
   assign bus.empty     = (count == '0);
   assign bus.state_dbg = (state == FLUSH);

   assign head_pc  = pc_mem[head];
   assign head_tgt = tgt_mem[head];
   assign head_hit = hit_mem[head];

   always_comb begin
      retire     = 1'b0;
      pc_bad     = 1'b0;
      mispredict = 1'b0;
      train      = 1'b0;
      push_ok    = 1'b0;
      state_nxt  = TRACK;
      pred_next  = head_hit ? head_tgt : head_pc + 16'd2;
      act_next   = (bus.wb_is_ctrl & bus.wb_taken) ? bus.wb_target : bus.wb_pc + 16'd2;
      case (state)
         TRACK: begin
            retire     = bus.wb_valid & ~bus.empty;
            pc_bad     = retire & (head_pc != bus.wb_pc);
            mispredict = retire & (pred_next != act_next);
            train      = retire & bus.wb_is_ctrl & bus.wb_taken &
                         (~head_hit | (head_tgt != bus.wb_target));
            // A retire frees its slot on the same edge, so full only blocks a lone push.
            push_ok    = bus.push_valid & (~bus.full | retire) & ~(pc_bad | mispredict);
            state_nxt  = (pc_bad | mispredict) ? FLUSH : TRACK;
         end
         FLUSH: state_nxt = TRACK;
         default: state_nxt = TRACK;
      endcase
   end

   assign flush = pc_bad | mispredict;

   always_ff @(posedge clk) begin
      if (rst) state <= TRACK;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         pc_mem[tail]  <= bus.push_pc;
         tgt_mem[tail] <= bus.push_target;
         hit_mem[tail] <= bus.push_hit;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= tail;
         count <= '0;
      end else begin
         if (retire)  head <= head + 1'b1;
         if (push_ok) tail <= tail + 1'b1;
         count <= count + (PTRW+1)'(push_ok) - (PTRW+1)'(retire);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.redirect          <= 1'b0;
         bus.redirect_pc       <= 16'h0000;
         bus.btb_update        <= 1'b0;
         bus.btb_update_pc     <= 16'h0000;
         bus.btb_update_target <= 16'h0000;
         bus.sync_err          <= 1'b0;
      end else begin
         bus.redirect   <= flush;
         bus.btb_update <= train;
         if (flush) bus.redirect_pc <= act_next;
         if (train) begin
            bus.btb_update_pc     <= bus.wb_pc;
            bus.btb_update_target <= bus.wb_target;
         end
         if (pc_bad) bus.sync_err <= 1'b1;
      end
   end

`ifdef BRVQ_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.stat_ctrl       <= 16'h0000;
         bus.stat_mispredict <= 16'h0000;
      end else begin
         if (retire & bus.wb_is_ctrl & (bus.stat_ctrl != 16'hFFFF))
            bus.stat_ctrl <= bus.stat_ctrl + 16'd1;
         // Sync errors redirect too but are not counted as mispredictions.
         if (mispredict & ~pc_bad & (bus.stat_mispredict != 16'hFFFF))
            bus.stat_mispredict <= bus.stat_mispredict + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_branch_verify_queue.sv
// Self-checking bench for branch_verify_queue: directed steps then random traffic vs a queue model.
// Stats checks are compiled in when BRVQ_STATS_EN is defined.
module tb_branch_verify_queue;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   branch_verify_queue_if bus();
   branch_verify_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_vec = 0;
   int n_err = 0;

   // Model: each entry is {pc, hit, target}; m_flush marks the dead cycle after a redirect.
   logic [32:0] exp_q[$];
   logic        m_flush = 1'b0;
   logic        e_red = 1'b0, e_btb = 1'b0, e_sync = 1'b0;
   logic [15:0] e_rpc = '0, e_bpc = '0, e_btgt = '0;
   int          m_ctrl = 0, m_mis = 0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic pv, input logic [15:0] ppc, input logic ph,
                      input logic [15:0] pt, input logic wv, input logic [15:0] wpc,
                      input logic wc, input logic wt, input logic [15:0] wtg);
      logic [32:0] e;
      logic [15:0] pred, act;
      logic        ret, bad, push_ok;
      int          sz;
      rst = r;
      bus.push_valid = pv; bus.push_pc = ppc; bus.push_hit = ph; bus.push_target = pt;
      bus.wb_valid = wv; bus.wb_pc = wpc; bus.wb_is_ctrl = wc; bus.wb_taken = wt;
      bus.wb_target = wtg;
      if (r) begin
         exp_q.delete();
         m_flush = 0; e_red = 0; e_btb = 0; e_sync = 0;
         e_rpc = '0; e_bpc = '0; e_btgt = '0; m_ctrl = 0; m_mis = 0;
      end else begin
         sz  = exp_q.size();
         ret = !m_flush && wv && sz > 0;
         bad = 1'b0;
         e_red = 0; e_btb = 0;
         if (ret) begin
            e    = exp_q.pop_front();
            pred = e[16] ? e[15:0] : e[32:17] + 16'd2;
            act  = (wc && wt) ? wtg : wpc + 16'd2;
            bad  = (pred != act) || (e[32:17] != wpc);
            if (bad) begin e_red = 1; e_rpc = act; end
            if (e[32:17] != wpc) e_sync = 1;
            else if (pred != act && m_mis < 65535) m_mis++;
            if (wc && m_ctrl < 65535) m_ctrl++;
            if (wc && wt && (!e[16] || e[15:0] != wtg)) begin
               e_btb = 1; e_bpc = wpc; e_btgt = wtg;
            end
         end
         push_ok = !m_flush && pv && (sz < DEPTH || ret) && !bad;
         if (bad) exp_q.delete();
         if (push_ok) exp_q.push_back({ppc, ph, pt});
         m_flush = bad;
      end
      @(posedge clk);
      #1;
      chk("redirect", 16'(bus.redirect), 16'(e_red));
      chk("redirect_pc", bus.redirect_pc, e_rpc);
      chk("btb_update", 16'(bus.btb_update), 16'(e_btb));
      chk("btb_update_pc", bus.btb_update_pc, e_bpc);
      chk("btb_update_target", bus.btb_update_target, e_btgt);
      chk("sync_err", 16'(bus.sync_err), 16'(e_sync));
      chk("full", 16'(bus.full), 16'(exp_q.size() == DEPTH));
      chk("empty", 16'(bus.empty), 16'(exp_q.size() == 0));
      chk("state_dbg", 16'(bus.state_dbg), 16'(m_flush));
`ifdef BRVQ_STATS_EN
      chk("stat_ctrl", bus.stat_ctrl, 16'(m_ctrl));
      chk("stat_mispredict", bus.stat_mispredict, 16'(m_mis));
`endif
   endtask

   task automatic idle();
      cyc(0, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 0, 16'h0);
   endtask
   task automatic push(input logic [15:0] pc, input logic hit, input logic [15:0] tgt);
      cyc(0, 1, pc, hit, tgt, 0, 16'h0, 0, 0, 16'h0);
   endtask
   task automatic retire(input logic [15:0] pc, input logic c, input logic t, input logic [15:0] tgt);
      cyc(0, 0, 16'h0, 0, 16'h0, 1, pc, c, t, tgt);
   endtask

   initial begin
      logic [15:0] rpc, rtgt, wpc, wtg;
      // Reset
      cyc(1, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 0, 16'h0);
      cyc(1, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 0, 16'h0);
      chk("rst_empty", 16'(bus.empty), 16'h1);
      chk("rst_redirect_pc", bus.redirect_pc, 16'h0000);

      // Sequential instruction, correctly predicted
      push(16'h3000, 0, 16'h0);
      retire(16'h3000, 0, 0, 16'h0);
      chk("seq_no_redirect", 16'(bus.redirect), 16'h0);

      // Taken BR missed by BTB; push during the flush cycle is dropped
      push(16'h3010, 0, 16'h0);
      retire(16'h3010, 1, 1, 16'h3040);
      chk("br_rpc", bus.redirect_pc, 16'h3040);
      chk("br_btb_pc", bus.btb_update_pc, 16'h3010);
      cyc(0, 1, 16'h3999, 0, 16'h0, 0, 16'h0, 0, 0, 16'h0);
      chk("flush_push_dropped", 16'(bus.empty), 16'h1);

      // Predicted taken, actually not taken
      push(16'h3020, 1, 16'h3100);
      retire(16'h3020, 1, 0, 16'h0);
      chk("nt_rpc", bus.redirect_pc, 16'h3022);
      chk("nt_no_btb", 16'(bus.btb_update), 16'h0);
      idle();

      // TRAP to a different target than the BTB holds
      push(16'h3030, 1, 16'h3100);
      retire(16'h3030, 1, 1, 16'h3200);
      chk("trap_rpc", bus.redirect_pc, 16'h3200);
      chk("trap_btb_tgt", bus.btb_update_target, 16'h3200);
      idle();

      // Fill, overflow, push+retire while full, and PC wrap at 0xFFFE
      for (int i = 0; i < DEPTH; i++) push(16'hFFF0 + 16'(2 * i), 0, 16'h0);
      chk("fill_full", 16'(bus.full), 16'h1);
      push(16'h1111, 0, 16'h0);
      cyc(0, 1, 16'h0000, 0, 16'h0, 1, 16'hFFF0, 0, 0, 16'h0);
      chk("full_pushpop", 16'(bus.full), 16'h1);
      for (int i = 1; i < DEPTH; i++) retire(16'hFFF0 + 16'(2 * i), 0, 0, 16'h0);
      chk("wrap_no_redirect", 16'(bus.redirect), 16'h0);
      retire(16'h0000, 0, 0, 16'h0);
      chk("drain_empty", 16'(bus.empty), 16'h1);

      // Random traffic, WB always names the head PC
      for (int n = 0; n < 400; n++) begin
         rpc  = 16'($urandom_range(0, 65535)) & 16'hFFFE;
         rtgt = ($urandom_range(0, 1) == 1) ? rpc + 16'd2 : 16'($urandom_range(0, 65535));
         wpc  = (exp_q.size() > 0) ? exp_q[0][32:17] : 16'($urandom_range(0, 65535));
         wtg  = (exp_q.size() > 0 && $urandom_range(0, 1) == 1) ? exp_q[0][15:0]
                                                               : 16'($urandom_range(0, 65535));
         cyc(0, 1'($urandom_range(0, 9) < 6), rpc, 1'($urandom_range(0, 1)), rtgt,
             1'($urandom_range(0, 1)), wpc, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), wtg);
      end

      // Sync error: sticky, and forces a redirect
      cyc(1, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 0, 16'h0);
      push(16'h3000, 0, 16'h0);
      retire(16'h4000, 0, 0, 16'h0);
      chk("sync_rpc", bus.redirect_pc, 16'h4002);
      idle();
      push(16'h3050, 0, 16'h0);
      retire(16'h3050, 0, 0, 16'h0);
      chk("sync_sticky", 16'(bus.sync_err), 16'h1);

`ifdef BRVQ_STATS_EN
      cyc(1, 0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 0, 16'h0);
      for (int i = 0; i < 3; i++) begin
         push(16'h3100, 0, 16'h0);
         retire(16'h3100, 1, 1, 16'h3180);
         idle();
      end
      chk("stat_mis3", bus.stat_mispredict, 16'd3);
`endif

      // Reset during a mispredicting retire suppresses the pulses
      push(16'h3060, 0, 16'h0);
      cyc(1, 0, 16'h0, 0, 16'h0, 1, 16'h3060, 1, 1, 16'h3300);
      chk("rst_mid_redirect", 16'(bus.redirect), 16'h0);
      chk("rst_mid_sync", 16'(bus.sync_err), 16'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
